// File: rtl/pc_pkg.sv
// Shared types and constants for the program-counter / run-control stage.
//   PC_W        : default PC / branch-target width
//   run_state_t : run-control FSM state encoding
//   pc_t        : PC-sized vector type
package pc_pkg;

  localparam int PC_W = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } run_state_t;

  typedef logic [PC_W-1:0] pc_t;

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC selection for the RUN state.
//   i_pc     : current PC
//   i_target : branch target (absolute) or two's-complement offset (relative)
//   i_br_abs : absolute branch request
//   i_br_rel : relative branch request
//   i_taken  : branch condition, qualifies both branch requests
//   o_pc_nxt : selected next PC
module pc_next_calc #(
  parameter int D = 10
) (
  input  logic [D-1:0] i_pc,
  input  logic [D-1:0] i_target,
  input  logic         i_br_abs,
  input  logic         i_br_rel,
  input  logic         i_taken,
  output logic [D-1:0] o_pc_nxt
);

  logic [D-1:0] w_pc_inc;
  logic [D-1:0] w_pc_rel;

  // Both sums are modulo 2**D: D-bit addition wraps naturally, and a
  // two's-complement offset added in D bits gives the signed result.
  assign w_pc_inc = i_pc + D'(1);
  assign w_pc_rel = i_pc + i_target;

  always_comb begin
    o_pc_nxt = w_pc_inc;
    if (i_taken && i_br_abs)      o_pc_nxt = i_target;   // absolute wins over relative
    else if (i_taken && i_br_rel) o_pc_nxt = w_pc_rel;
  end

endmodule

// File: rtl/prog_ctr_fsm.sv
// Program counter and start/halt run control.
//   Clk      : clock, rising edge
//   Reset    : synchronous active-high reset
//   Start    : begin execution at PC 0 (honoured in IDLE / HALT)
//   Stall    : freeze PC, counter and state while running
//   BrAbs    : absolute branch request
//   BrRel    : relative branch request
//   Taken    : branch condition
//   Target   : branch target / signed offset
//   HaltReq  : decoded halt instruction
//   ProgCtr  : current PC (instruction ROM address)
//   Running  : high in RUN
//   Done     : high in HALT
//   InstCnt  : instructions retired since the last Start (saturating)
module prog_ctr_fsm
  import pc_pkg::*;
#(
  parameter int D  = PC_W,
  parameter int CW = 16
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Start,
  input  logic          Stall,
  input  logic          BrAbs,
  input  logic          BrRel,
  input  logic          Taken,
  input  logic [D-1:0]  Target,
  input  logic          HaltReq,
  output logic [D-1:0]  ProgCtr,
  output logic          Running,
  output logic          Done,
  output logic [CW-1:0] InstCnt
);

  run_state_t    r_state, w_state_nxt;
  logic [D-1:0]  r_pc, w_pc_nxt, w_pc_calc;
  logic [CW-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;

  pc_next_calc #(.D(D)) u_next (
    .i_pc     (r_pc),
    .i_target (Target),
    .i_br_abs (BrAbs),
    .i_br_rel (BrRel),
    .i_taken  (Taken),
    .o_pc_nxt (w_pc_calc)
  );

  // Retired-instruction count sticks at all-ones instead of wrapping.
  assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + CW'(1);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= IDLE;
      r_pc    <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      IDLE, HALT: begin
        if (Start) begin
          w_state_nxt = RUN;
          w_pc_nxt    = '0;
          w_cnt_nxt   = '0;
        end
      end
      RUN: begin
        // A stalled cycle retires nothing, so halt and branches wait too.
        if (!Stall) begin
          w_cnt_nxt = w_cnt_inc;
          if (HaltReq) w_state_nxt = HALT;   // halt instruction retires, PC holds
          else         w_pc_nxt    = w_pc_calc;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign ProgCtr = r_pc;
  assign InstCnt = r_cnt;
  assign Running = (r_state == RUN);
  assign Done    = (r_state == HALT);

endmodule

// File: tb/tb_prog_ctr_fsm.sv
module tb_prog_ctr_fsm;

  localparam int D  = 10;
  localparam int CW = 4;

  logic          Clk = 1'b0;
  logic          Reset, Start, Stall, BrAbs, BrRel, Taken, HaltReq;
  logic [D-1:0]  Target;
  logic [D-1:0]  ProgCtr;
  logic          Running, Done;
  logic [CW-1:0] InstCnt;

  int nchk = 0;
  int nerr = 0;

  prog_ctr_fsm #(.D(D), .CW(CW)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Stall(Stall),
    .BrAbs(BrAbs), .BrRel(BrRel), .Taken(Taken), .Target(Target),
    .HaltReq(HaltReq), .ProgCtr(ProgCtr), .Running(Running),
    .Done(Done), .InstCnt(InstCnt)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // pc / running / done / count in one go
  task automatic chk_all(input string tag, input int pc, input int run,
                         input int dn, input int cnt);
    chk({tag, ".pc"},   int'(ProgCtr), pc);
    chk({tag, ".run"},  int'(Running), run);
    chk({tag, ".done"}, int'(Done),    dn);
    chk({tag, ".cnt"},  int'(InstCnt), cnt);
  endtask

  task automatic clr();
    Start = 0; Stall = 0; BrAbs = 0; BrRel = 0; Taken = 0; HaltReq = 0; Target = '0;
  endtask

  task automatic jump(input int v);
    BrAbs = 1; Taken = 1; Target = D'(v);
    tick();
    clr();
  endtask

  initial begin
    clr();
    Reset = 1;
    tick(); tick();
    chk_all("reset", 0, 0, 0, 0);
    Reset = 0;

    // IDLE ignores everything but Start
    Stall = 1; BrAbs = 1; Taken = 1; Target = 10'd77; HaltReq = 1;
    tick(); tick();
    chk_all("idle_ign", 0, 0, 0, 0);
    clr();

    // Start then 5 sequential cycles
    Start = 1; tick(); Start = 0;
    chk_all("start", 0, 1, 0, 0);
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk("seq.pc", int'(ProgCtr), i);
    end
    chk_all("seq5", 5, 1, 0, 5);
    Start = 1; tick(); Start = 0;          // Start in RUN ignored
    chk_all("start_run", 6, 1, 0, 6);
    for (int i = 0; i < 5; i++) tick();
    chk_all("pc11", 11, 1, 0, 11);

    jump(80);
    chk_all("abs80", 80, 1, 0, 12);
    jump(11);                               // back to 11, cnt 13
    BrAbs = 1; Taken = 0; Target = 10'd80; tick(); clr();
    chk_all("abs_nt", 12, 1, 0, 14);
    tick();
    chk_all("cnt_max", 13, 1, 0, 15);
    tick();
    chk_all("cnt_sat", 14, 1, 0, 15);

    // relative branches
    jump(4);
    BrRel = 1; Taken = 1; Target = 10'h3FF; tick(); clr();
    chk("rel_m1.pc", int'(ProgCtr), 3);
    jump(4);
    BrRel = 1; Taken = 1; Target = 10'd20; tick(); clr();
    chk("rel_p20.pc", int'(ProgCtr), 24);
    BrRel = 1; Taken = 0; Target = 10'd20; tick(); clr();
    chk("rel_nt.pc", int'(ProgCtr), 25);
    jump(1023);
    chk("pc1023", int'(ProgCtr), 1023);
    tick();
    chk("wrap.pc", int'(ProgCtr), 0);

    // both branch kinds: absolute wins
    jump(5);
    BrAbs = 1; BrRel = 1; Taken = 1; Target = 10'd113; tick(); clr();
    chk("both.pc", int'(ProgCtr), 113);

    // stall blocks halt and branches
    jump(59);
    Stall = 1; HaltReq = 1; BrAbs = 1; Taken = 1; Target = 10'd200;
    tick();
    chk_all("stall1", 59, 1, 0, 15);
    tick();
    chk_all("stall2", 59, 1, 0, 15);
    clr();
    HaltReq = 1; tick(); clr();
    chk_all("halt", 59, 0, 1, 15);
    BrAbs = 1; Taken = 1; Target = 10'd9; HaltReq = 1; Stall = 1;
    tick(); clr();
    chk_all("halt_hold", 59, 0, 1, 15);
    Start = 1; tick(); Start = 0;
    chk_all("restart", 0, 1, 0, 0);

    // stall holds counter; halt instruction retires
    Stall = 1; tick(); clr();
    chk_all("stall_cnt", 0, 1, 0, 0);
    tick();
    chk_all("run1", 1, 1, 0, 1);
    HaltReq = 1; tick(); clr();
    chk_all("halt_cnt", 1, 0, 1, 2);
    Start = 1; tick(); Start = 0;
    chk_all("restart2", 0, 1, 0, 0);

    // reset mid-RUN
    jump(68);
    chk("pc68", int'(ProgCtr), 68);
    Reset = 1; Start = 1; BrAbs = 1; Taken = 1; Target = 10'd5;
    tick();
    Reset = 0; clr();
    chk_all("rst_run", 0, 0, 0, 0);
    Stall = 1; BrRel = 1; Taken = 1; Target = 10'd3; HaltReq = 1;
    tick(); tick(); clr();
    chk_all("rst_idle", 0, 0, 0, 0);
    Start = 1; tick(); Start = 0;
    tick();
    chk_all("rst_start", 1, 1, 0, 1);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
